dmem_sram_like_bridge: RTL and testbench
========================================

// Module: dmem_sram_like_bridge
// PURPOSE
//  Sits between the MEM-stage byte-lane selector and the data-side sram-like bus (req/addr_ok/data_ok).
//  Turns one MEM-stage access into exactly one bus transaction, then returns the raw 32-bit word for
//  load extraction. Drives the MEM-stage stall. Absorbs exception flushes without breaking the bus protocol.
// PARAMETERS
//  TIMEOUT  1024  cycles in ADDR+DATA before bus_timeout sets; 0 = watchdog disabled
// PORTS
//  clk            in   1   clock; all logic on posedge
//  rst            in   1   synchronous, active-high reset
//  mem_valid      in   1   MEM stage holds a load/store with no address error
//  mem_wr         in   1   1 = store, 0 = load
//  mem_size       in   2   0 byte, 1 half, 2 word
//  mem_addr       in   32  byte address, from the ALU result
//  mem_wdata      in   32  lane-replicated store data (writedata2)
//  mem_flush      in   1   exception/flush of the MEM-stage instruction
//  pipe_stall     in   1   stall from any other source (e.g. fetch side)
//  data_req       out  1   sram-like request
//  data_wr        out  1   sram-like write
//  data_size      out  2   sram-like size
//  data_addr      out  32  sram-like address
//  data_wdata     out  32  sram-like write data
//  data_addr_ok   in   1   address accepted
//  data_data_ok   in   1   read data valid / write complete
//  data_rdata     in   32  read data
//  mem_rdata      out  32  held read word (readdata for load extraction)
//  mem_stall      out  1   MEM stage must hold
//  bus_timeout    out  1   sticky watchdog flag
// BEHAVIOUR
//  Reset: state=IDLE. data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0.
//   mem_rdata=0, discard=0, wd_cnt=0, bus_timeout=0.
//  FSM states: IDLE, ADDR, DATA, DONE. Outputs are registered. data_req = (state==ADDR).
//  IDLE:
//   - mem_valid & ~mem_flush -> ADDR.
//   - Latch mem_wr/size/addr/wdata into the data_* registers. data_req rises the next cycle.
//  ADDR:
//   - data_addr_ok -> DATA.
//   - data_req and all data_* fields stay stable until addr_ok. The request is never withdrawn.
//  DATA:
//   - data_data_ok -> DONE.
//   - Capture data_rdata into mem_rdata for loads. mem_rdata is left unchanged for stores.
//   - If discard=1, go to IDLE instead, clear discard, and leave mem_rdata unchanged.
//   - addr_ok is ignored in DATA. Only one transaction is outstanding.
//  DONE:
//   - ~pipe_stall | mem_flush -> IDLE.
//   - mem_rdata is held for the whole of DONE.
//  mem_flush in ADDR or DATA: set discard. The transaction still completes on the bus.
//   No DONE visit follows, so the result never reaches writeback.
//  mem_stall = (IDLE & mem_valid & ~mem_flush) | ADDR | DATA. It is 0 in DONE.
//   A flush has priority over stall in the hazard unit. The bridge stays busy and stalls the next access.
//  Minimum access: IDLE(1) + ADDR(1, addr_ok same cycle) + DATA(1, data_ok same cycle) + DONE.
//   This gives 3 stall cycles.
//  Watchdog:
//   - wd_cnt increments in ADDR/DATA and clears on entering IDLE/DONE.
//   - wd_cnt saturates at TIMEOUT, and bus_timeout sets when wd_cnt==TIMEOUT.
//   - bus_timeout is sticky until rst. The FSM is not aborted.
//  Reset mid-transaction returns to IDLE immediately. The interconnect is reset by the same rst.
//  Address errors are filtered upstream: mem_valid is low for misaligned SW/SH/LW/LH/LHU.
// STRUCTURE
//  Shared defines header: state encodings (2-bit) and size codes SZ_BYTE/SZ_HALF/SZ_WORD.
//  Single module. No sub-module; the watchdog counter is inline.
//  The size code comes from the op decode in MEM, computed upstream of this block.
// TESTING
//  1. LW addr 0x1000, addr_ok and data_ok each 1 cycle after req, rdata 0xDEADBEEF
//     -> mem_rdata=0xDEADBEEF in DONE; mem_stall high exactly 3 cycles.
//  2. SB addr 0x2003, wdata 0x5A5A5A5A, addr_ok delayed 4 cycles
//     -> data_req/addr/wdata/size=0/wr=1 stable all 4 cycles; single transaction.
//  3. Flush asserted while in DATA for LW
//     -> data_ok still consumed, FSM returns to IDLE, mem_rdata keeps its old value, no DONE.
//  4. data_ok with pipe_stall=1 for 5 cycles
//     -> FSM stays in DONE, mem_stall=0, mem_rdata constant; a second req is not issued.
//  5. TIMEOUT=8, addr_ok never arrives
//     -> bus_timeout rises on cycle 8 of ADDR and stays high; rst clears it, with outputs at reset values.
//  6. Back-to-back LW then SW, pipe_stall=0
//     -> two distinct transactions; the second req is one cycle after DONE; no overlap.

Source files
------------

// File: rtl/dmem_sram_like_bridge_pkg.sv
// Shared definitions for the data-side sram-like bridge.
// Holds the FSM state encoding and the bus size codes.
package dmem_sram_like_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic is_busy(input state_e s);
    return (s == ST_ADDR) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/dmem_sram_like_bridge.sv
// MEM-stage to sram-like data bus bridge: one bus transaction per access,
// held read word for load extraction, MEM stall and sticky bus watchdog.
module dmem_sram_like_bridge
  import dmem_sram_like_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_wr,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_flush,
  input  logic        pipe_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        bus_timeout
);

  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic            data_req_q, data_req_d;
  logic            data_wr_q, data_wr_d;
  logic [1:0]      data_size_q, data_size_d;
  logic [31:0]     data_addr_q, data_addr_d;
  logic [31:0]     data_wdata_q, data_wdata_d;
  logic [31:0]     mem_rdata_q, mem_rdata_d;
  logic            discard_q, discard_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            bus_timeout_q, bus_timeout_d;
  logic            discard_eff;
  logic [WD_W-1:0] wd_inc;

  always_comb begin
    state_d       = state_q;
    data_wr_d     = data_wr_q;
    data_size_d   = data_size_q;
    data_addr_d   = data_addr_q;
    data_wdata_d  = data_wdata_q;
    mem_rdata_d   = mem_rdata_q;
    discard_d     = discard_q;
    bus_timeout_d = bus_timeout_q;
    // A flush arriving together with data_ok still drops the result.
    discard_eff   = discard_q | mem_flush;

    unique case (state_q)
      ST_IDLE: begin
        if (mem_valid && !mem_flush) begin
          state_d      = ST_ADDR;
          data_wr_d    = mem_wr;
          data_size_d  = mem_size;
          data_addr_d  = mem_addr;
          data_wdata_d = mem_wdata;
        end
      end
      ST_ADDR: begin
        if (mem_flush) discard_d = 1'b1;
        if (data_addr_ok) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (mem_flush) discard_d = 1'b1;
        if (data_data_ok) begin
          if (discard_eff) begin
            state_d   = ST_IDLE;
            discard_d = 1'b0;
          end else begin
            state_d = ST_DONE;
            if (!data_wr_q) mem_rdata_d = data_rdata;
          end
        end
      end
      ST_DONE: begin
        if (!pipe_stall || mem_flush) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    data_req_d = (state_d == ST_ADDR);

    // Counts every busy cycle, including the one that leaves ADDR/DATA.
    wd_inc   = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
    wd_cnt_d = '0;
    if (is_busy(state_q) && is_busy(state_d)) wd_cnt_d = wd_inc;
    if ((TIMEOUT != 0) && is_busy(state_q) && (wd_inc == WD_MAX)) bus_timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      data_req_q    <= 1'b0;
      data_wr_q     <= 1'b0;
      data_size_q   <= '0;
      data_addr_q   <= '0;
      data_wdata_q  <= '0;
      mem_rdata_q   <= '0;
      discard_q     <= 1'b0;
      wd_cnt_q      <= '0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      data_req_q    <= data_req_d;
      data_wr_q     <= data_wr_d;
      data_size_q   <= data_size_d;
      data_addr_q   <= data_addr_d;
      data_wdata_q  <= data_wdata_d;
      mem_rdata_q   <= mem_rdata_d;
      discard_q     <= discard_d;
      wd_cnt_q      <= wd_cnt_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  assign data_req    = data_req_q;
  assign data_wr     = data_wr_q;
  assign data_size   = data_size_q;
  assign data_addr   = data_addr_q;
  assign data_wdata  = data_wdata_q;
  assign mem_rdata   = mem_rdata_q;
  assign bus_timeout = bus_timeout_q;
  assign mem_stall   = ((state_q == ST_IDLE) && mem_valid && !mem_flush) || is_busy(state_q);

endmodule

// File: tb/tb_dmem_sram_like_bridge.sv
// Self-checking bench for dmem_sram_like_bridge: transaction-level model plus
// directed scenarios with literal expectations.
module tb_dmem_sram_like_bridge;
  import dmem_sram_like_bridge_pkg::*;

  localparam int unsigned TO = 8;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0, mem_wr = 1'b0, mem_flush = 1'b0, pipe_stall = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [31:0] mem_addr = '0, mem_wdata = '0;
  logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
  logic [31:0] data_rdata = '0;
  logic        data_req, data_wr, mem_stall, bus_timeout;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, mem_rdata;

  dmem_sram_like_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_flush(mem_flush), .pipe_stall(pipe_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_rdata(mem_rdata), .mem_stall(mem_stall), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Bus slave: addr_ok after a_dly request cycles, data_ok d_dly cycles into the data phase.
  int          a_dly = 0, d_dly = 0;
  logic [31:0] rd_word = '0;
  int          bph = 0, bcnt = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      bph = 0; bcnt = 0;
    end else begin
      if (bph == 1 && data_addr_ok) begin bph = 2; bcnt = 0; end
      else if (bph == 2 && data_data_ok) bph = 0;
      else if (bph != 0) bcnt++;
      if (bph == 0 && data_req) begin bph = 1; bcnt = 0; end
    end
    data_addr_ok = (bph == 1) && (bcnt >= a_dly);
    data_data_ok = (bph == 2) && (bcnt >= d_dly);
    data_rdata   = (bph == 2) ? rd_word : 32'h0;
  end

  // Reference model: phase 0 free, 1 requesting, 2 awaiting data, 3 holding result.
  int          m_ph = 0, m_cyc = 0;
  bit          m_disc = 0, m_to = 0, m_live = 0;
  logic        m_wr = 0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  int          n_addr = 0, n_data = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_cyc = 0; m_disc = 0; m_to = 0; m_live = 1;
      m_wr = 0; m_size = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    end else begin
      if (data_req && data_addr_ok) n_addr++;
      if (data_data_ok) n_data++;
      case (m_ph)
        0: if (mem_valid && !mem_flush) begin
          m_ph = 1; m_cyc = 0;
          m_wr = mem_wr; m_size = mem_size; m_addr = mem_addr; m_wdata = mem_wdata;
        end
        1, 2: begin
          m_cyc++;
          if (m_cyc >= TO) m_to = 1;
          if (mem_flush) m_disc = 1;
          if (m_ph == 1) begin
            if (data_addr_ok) m_ph = 2;
          end else if (data_data_ok) begin
            if (!m_disc && !m_wr) m_rdata = data_rdata;
            m_ph = m_disc ? 0 : 3;
            m_disc = 0;
          end
        end
        default: if (!pipe_stall || mem_flush) m_ph = 0;
      endcase
    end
  end

  int stall_cnt = 0;

  always @(negedge clk) begin
    if (mem_stall === 1'b1) stall_cnt++;
    if (m_live) begin
      chk("m_req",     32'(data_req),    32'(m_ph == 1));
      chk("m_wr",      32'(data_wr),     32'(m_wr));
      chk("m_size",    32'(data_size),   32'(m_size));
      chk("m_addr",    data_addr,        m_addr);
      chk("m_wdata",   data_wdata,       m_wdata);
      chk("m_rdata",   mem_rdata,        m_rdata);
      chk("m_stall",   32'(mem_stall),
          32'((m_ph == 0 && mem_valid && !mem_flush) || m_ph == 1 || m_ph == 2));
      chk("m_timeout", 32'(bus_timeout), 32'(m_to));
    end
  end

  task automatic start_access(input logic wr, input logic [1:0] sz, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ad, input int dd,
                              input logic [31:0] rword);
    mem_valid = 1'b1; mem_wr = wr; mem_size = sz; mem_addr = addr; mem_wdata = wdata;
    a_dly = ad; d_dly = dd; rd_word = rword;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(posedge clk); #2; n++;
    end while (mem_stall && n < 40);
    checks++;
    if (mem_stall) begin
      errors++;
      $display("FAIL %s_done: mem_stall still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  task automatic idle_cycle();
    mem_valid = 1'b0; mem_flush = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic chk_reset_values(input string name);
    chk({name, "_req"},     32'(data_req),    32'h0);
    chk({name, "_wr"},      32'(data_wr),     32'h0);
    chk({name, "_size"},    32'(data_size),   32'h0);
    chk({name, "_addr"},    data_addr,        32'h0);
    chk({name, "_wdata"},   data_wdata,       32'h0);
    chk({name, "_rdata"},   mem_rdata,        32'h0);
    chk({name, "_stall"},   32'(mem_stall),   32'h0);
    chk({name, "_timeout"}, 32'(bus_timeout), 32'h0);
  endtask

  initial begin
    int s0, na, nd, n;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_values("rst0");
    rst = 1'b0;
    @(posedge clk); #2;

    // LW, minimum latency
    s0 = stall_cnt;
    start_access(1'b0, SZ_WORD, 32'h0000_1000, 32'h0, 0, 0, 32'hDEAD_BEEF);
    wait_done("t1");
    chk("t1_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("t1_stall_cycles", 32'(stall_cnt - s0), 32'd3);
    idle_cycle();

    // LW then SW back to back
    na = n_addr;
    start_access(1'b0, SZ_WORD, 32'h0000_1004, 32'h0, 0, 0, 32'h1122_3344);
    wait_done("t6a");
    @(posedge clk); #2;
    start_access(1'b1, SZ_WORD, 32'h0000_1008, 32'hA5A5_0F0F, 0, 0, 32'h0);
    chk("t6_gap_req", 32'(data_req), 32'h0);
    @(posedge clk); #2;
    chk("t6_second_req", 32'(data_req), 32'h1);
    chk("t6_second_addr", data_addr, 32'h0000_1008);
    wait_done("t6b");
    chk("t6_txn_count", 32'(n_addr - na), 32'd2);
    chk("t6_rdata_kept", mem_rdata, 32'h1122_3344);
    idle_cycle();

    // SB with addr_ok delayed 4 cycles
    na = n_addr; nd = n_data;
    start_access(1'b1, SZ_BYTE, 32'h0000_2003, 32'h5A5A_5A5A, 4, 1, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      chk("t2_req",   32'(data_req),  32'h1);
      chk("t2_addr",  data_addr,      32'h0000_2003);
      chk("t2_wdata", data_wdata,     32'h5A5A_5A5A);
      chk("t2_size",  32'(data_size), 32'(SZ_BYTE));
      chk("t2_wr",    32'(data_wr),   32'h1);
    end
    wait_done("t2");
    chk("t2_addr_hs", 32'(n_addr - na), 32'd1);
    chk("t2_data_hs", 32'(n_data - nd), 32'd1);
    idle_cycle();

    // Flush during the data phase of a LW
    pipe_stall = 1'b1;
    start_access(1'b0, SZ_WORD, 32'h0000_1010, 32'h0, 0, 2, 32'h9999_9999);
    n = 0;
    do begin @(posedge clk); #2; n++; end while (bph != 2 && n < 20);
    chk("t3_reach_data", 32'(bph), 32'd2);
    mem_flush = 1'b1;
    @(posedge clk); #2;
    mem_flush = 1'b0; mem_valid = 1'b0;
    nd = n_data; n = 0;
    do begin @(posedge clk); #2; n++; end while (n_data == nd && n < 20);
    chk("t3_data_ok_taken", 32'(n_data - nd), 32'd1);
    chk("t3_rdata_kept", mem_rdata, 32'h1122_3344);
    chk("t3_stall", 32'(mem_stall), 32'h0);

    // Next access must launch at once (no DONE after discard), then hold with pipe_stall
    start_access(1'b0, SZ_WORD, 32'h0000_3000, 32'h0, 0, 0, 32'hCAFE_F00D);
    @(posedge clk); #2;
    chk("t3_no_done", 32'(data_req), 32'h1);
    wait_done("t4");
    na = n_addr;
    for (int k = 0; k < 5; k++) begin
      chk("t4_stall", 32'(mem_stall), 32'h0);
      chk("t4_req",   32'(data_req),  32'h0);
      chk("t4_rdata", mem_rdata,      32'hCAFE_F00D);
      @(posedge clk); #2;
    end
    chk("t4_no_new_txn", 32'(n_addr - na), 32'd0);
    pipe_stall = 1'b0;
    idle_cycle();

    // Watchdog: addr_ok never arrives
    start_access(1'b0, SZ_WORD, 32'h0000_4000, 32'h0, NEVER, 0, 32'h0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #2;
      chk("t5_req", 32'(data_req), 32'h1);
      chk("t5_timeout", 32'(bus_timeout), 32'(k >= 9));
    end
    rst = 1'b1; mem_valid = 1'b0;
    @(posedge clk); #2;
    chk_reset_values("t5_rst");
    rst = 1'b0;
    @(posedge clk); #2;
    chk("t5_after_rst_timeout", 32'(bus_timeout), 32'h0);
    chk("t5_after_rst_req", 32'(data_req), 32'h0);
    repeat (2) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
